// File: rtl/chunk_adder_pkg.sv
// Shared types and configuration checks for chunk_adder.
package chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Legal when the operand splits into a whole number of non-empty chunks.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_adder_slice.sv
// Combinational W-bit ripple-carry adder used as the per-cycle datapath of chunk_adder.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carryin,
  output logic [W-1:0] sum,
  output logic         carryout,
  output logic         carry_msb
);

  logic c;

  // NOTE: every variable written here gets a default first, so the block can never infer a latch.
  always_comb begin
    c         = carryin;
    sum       = '0;
    carry_msb = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) carry_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carryout = c;
  end

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder processing CHUNK bits per clock, LSB chunk first.
// Define CHUNK_ADDER_SUBTRACT_EN to add the sub port (a-b via inverted b and carry-in 1).
module chunk_adder
  import chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CHUNK_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carryout_q, carryout_d;
  logic               overflow_q, overflow_d;
  logic               start_ready_q, start_ready_d;
  logic               result_valid_q, result_valid_d;

  logic               sub_in;
  logic [CHUNK-1:0]   slice_a, slice_b, slice_sum;
  logic               slice_co, slice_cmsb;

`ifdef CHUNK_ADDER_SUBTRACT_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign slice_a = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
  assign slice_b = CHUNK'(b_q >> (int'(idx_q) * CHUNK));

  adder_slice #(.W(CHUNK)) u_slice (
    .a        (slice_a),
    .b        (slice_b),
    .carryin  (carry_q),
    .sum      (slice_sum),
    .carryout (slice_co),
    .carry_msb(slice_cmsb)
  );

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    carry_d        = carry_q;
    idx_d          = idx_q;
    sum_d          = sum_q;
    carryout_d     = carryout_q;
    overflow_d     = overflow_q;
    start_ready_d  = start_ready_q;
    result_valid_d = result_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          a_d           = a;
          // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
          b_d           = sub_in ? ~b : b;
          carry_d       = sub_in;
          idx_d         = '0;
          start_ready_d = 1'b0;
          state_d       = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q) * CHUNK +: CHUNK] = slice_sum;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          carryout_d     = slice_co;
          overflow_d     = slice_cmsb ^ slice_co;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          start_ready_d  = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      a_q            <= '0;
      b_q            <= '0;
      carry_q        <= 1'b0;
      idx_q          <= '0;
      sum_q          <= '0;
      carryout_q     <= 1'b0;
      overflow_q     <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      carry_q        <= carry_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      carryout_q     <= carryout_d;
      overflow_q     <= overflow_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign sum          = sum_q;
  assign carryout     = carryout_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboard bench for chunk_adder at WIDTH=8, CHUNK=4.
module tb_chunk_adder;

  localparam int WIDTH = 8;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sub = 1'b0;
  logic             result_valid;
  logic             result_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;

  chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
`ifdef CHUNK_ADDER_SUBTRACT_EN
    .sub         (sub),
`endif
    .result_valid(result_valid),
    .result_ready(result_ready),
    .sum         (sum),
    .carryout    (carryout),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ov;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares the first cycle of each result, pops on handshake.
  bit seen = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (result_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          check("sum", 32'(sum), 32'(exp_q[0].sum));
          check("carryout", 32'(carryout), 32'(exp_q[0].co));
          check("overflow", 32'(overflow), 32'(exp_q[0].ov));
          check("latency", 32'(cyc - exp_q[0].acc), 32'(N));
        end
      end
      if (result_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic si,
                       input logic [WIDTH-1:0] es, input logic eco, input logic eov);
    bit got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    a = ai;
    b = bi;
    sub = si;
    start_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      if (start_ready) begin
        e.sum = es;
        e.co  = eco;
        e.ov  = eov;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        got = 1'b1;
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic si,
                     input logic [WIDTH-1:0] es, input logic eco, input logic eov);
    issue(ai, bi, si, es, eco, eov);
    drain();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carryout", 32'(carryout), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run(8'h3C, 8'h4B, 1'b0, 8'h87, 1'b0, 1'b1);
    run(8'hF0, 8'hF0, 1'b0, 8'hE0, 1'b1, 1'b0);
`ifdef CHUNK_ADDER_SUBTRACT_EN
    run(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run(8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0);
`endif

    // Back-pressure: result held for 5 cycles while a new start is offered.
    result_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
    check("stall_valid_seen", 32'(result_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a = 8'hAA;
      b = 8'h55;
      start_valid = 1'b1;
      @(negedge clk);
      check("stall_result_valid", 32'(result_valid), 32'd1);
      check("stall_start_ready", 32'(start_ready), 32'd0);
      check("stall_sum", 32'(sum), 32'h46);
      check("stall_carryout", 32'(carryout), 32'd0);
      check("stall_overflow", 32'(overflow), 32'd0);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    drain();
    @(negedge clk);
    check("post_stall_ready", 32'(start_ready), 32'd1);

    // Reset while RUN: operation aborted with no result.
    a = 8'h7F;
    b = 8'h01;
    sub = 1'b0;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    check("abort_in_run", 32'(start_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_start_ready", 32'(start_ready), 32'd1);
    check("abort_result_valid", 32'(result_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_result", 32'(result_valid), 32'd0);

    run(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_valid  input  1  operands a, b (and sub) valid.
REQ-006 SHALL have port start_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand, 2's complement.
REQ-008 SHALL have port b  input  WIDTH  second operand, 2's complement.
REQ-009 SHALL have port sub  input  1  1 = a-b, 0 = a+b (present only with SUBTRACT_EN).
REQ-010 SHALL have port result_valid  output  1  sum/carryout/overflow valid.
REQ-011 SHALL have port result_ready  input  1  consumer takes result.
REQ-012 SHALL have port sum  output  WIDTH  2's complement result.
REQ-013 SHALL have port carryout  output  1  carry out of MSB.
REQ-014 SHALL have port overflow  output  1  signed overflow.

Function
REQ-015 SHALL require WIDTH % CHUNK == 0 and CHUNK <= WIDTH; N = WIDTH/CHUNK; elaboration error otherwise.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL assert start_ready only in IDLE; start_valid outside IDLE ignored.
REQ-018 SHALL on start_valid && start_ready latch a, b, sub, clear carry (or set to 1 if subtracting) and go IDLE->RUN.
REQ-019 SHALL in RUN add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) per cycle, LSB chunk first, chaining carry via register.
REQ-020 SHALL go RUN->DONE after chunk N-1; result_valid high exactly N cycles after the accept edge.
REQ-021 SHALL hold result_valid, sum, carryout, overflow stable in DONE until result_valid && result_ready, then go DONE->IDLE.
REQ-022 SHALL not accept new operands in the same cycle the result is taken; earliest accept is the following cycle.
REQ-023 SHALL compute carryout = carry out of bit WIDTH-1; overflow = carry into bit WIDTH-1 XOR carryout.
REQ-024 SHALL wrap sum modulo 2^WIDTH.
REQ-025 SHALL leave sum/carryout/overflow unspecified outside DONE except after reset.

Reset
REQ-026 SHALL on reset go to IDLE in the same edge, aborting any RUN/DONE operation without producing a result.
REQ-027 SHALL reset start_ready=1 (after edge), result_valid=0, sum=0, carryout=0, overflow=0, carry/chunk index=0.
REQ-028 SHALL give reset priority over start and result handshakes in the same cycle.

Configuration
REQ-029 SHALL use macro CHUNK_ADDER_SUBTRACT_EN: defined -> sub port present, b inverted and carry-in 1 when sub=1, carryout = NOT borrow.
REQ-030 SHALL without CHUNK_ADDER_SUBTRACT_EN omit sub port and perform addition only with carry-in 0.

Structure
REQ-031 SHALL place state enum (IDLE/RUN/DONE) and WIDTH/CHUNK legality check function in package chunk_adder_pkg.
REQ-032 SHALL instantiate one combinational sub-module adder_slice (CHUNK-bit ripple adder, ports a, b, carryin, sum, carryout, carry into MSB).

Verification (WIDTH=8, CHUNK=4, N=2)
REQ-033 SHALL cover 0x7F+0x01 -> sum 0x80, carryout 0, overflow 1, result_valid 2 cycles after accept.
REQ-034 SHALL cover 0xFF+0x01 -> sum 0x00, carryout 1, overflow 0.
REQ-035 SHALL cover result_ready low 5 cycles in DONE -> outputs held, start_ready 0, new start_valid ignored.
REQ-036 SHALL cover reset asserted in RUN -> next cycle start_ready 1, result_valid 0, sum 0, no result emitted.
REQ-037 SHALL cover (SUBTRACT_EN) 0x05-0x07 -> 0xFE, carryout 0, overflow 0; 0x80-0x01 -> 0x7F, carryout 1, overflow 1.
